// File: rtl/ntt_perm_pkg.sv
// ============================================================================
// Package     : ntt_perm_pkg
// Description : Shared definitions for the NTT stage permutation stream:
//               lane index width, lane-array type, stage width and the
//               lane-index bit-swap function that defines the permutation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ntt_perm_pkg;

  // Widest supported lane count is 128 lanes, so a lane index needs 7 bits
  localparam int LANE_IDX_W  = 7;
  localparam int STAGE_W_MAX = LANE_IDX_W;

  // Default build geometry (64 lanes of 28 bits)
  localparam int DEFAULT_LANES  = 64;
  localparam int DEFAULT_LANE_W = 28;
  localparam int DEFAULT_STAGE_W = $clog2(DEFAULT_LANES);

  typedef logic [LANE_IDX_W-1:0] lane_idx_t;
  typedef logic [DEFAULT_LANES-1:0][DEFAULT_LANE_W-1:0] lane_array_t;

  // Width of the stage select for a given lane count
  function automatic int stage_width(input int lanes);
    return $clog2(lanes);
  endfunction

  // Source lane for output lane idx: swap index bits 0 and k.
  // k = 0 or k outside the index width leaves the index unchanged.
  function automatic int swap_lane_bits(input int idx, input int k, input int lane_bits);
    int r;
    int b0;
    int bk;
    r = idx;
    if ((k > 0) && (k < lane_bits)) begin
      b0 = idx & 1;
      bk = (idx >> k) & 1;
      r  = (idx & ~((1 << k) | 1)) | (b0 << k) | bk;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/perm_skid_buffer.sv
// ============================================================================
// Module      : perm_skid_buffer
// Description : Two-entry valid/ready buffer with a registered output side.
//               A full buffer still takes a beat in a cycle where one leaves.
//               The input side stays closed while reset is high and opens on
//               the first clock edge after release.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module perm_skid_buffer #(
  parameter int PAYLOAD_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload
);

  logic [1:0][PAYLOAD_W-1:0] mem;
  logic                      wr_ptr;
  logic                      rd_ptr;
  logic [1:0]                count;
  logic                      open_q;
  logic                      push;
  logic                      pop;

  assign out_valid   = (count != 2'd0);
  assign out_payload = mem[rd_ptr];
  assign in_ready    = open_q && ((count != 2'd2) || out_ready);
  assign push        = in_valid && in_ready;
  assign pop         = out_valid && out_ready;

  // Open the input side one cycle after reset release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) open_q <= 1'b0;
    else     open_q <= 1'b1;
  end

  // Payload storage; cleared on reset so the output reads zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       mem         <= '0;
    else if (push) mem[wr_ptr] <= in_payload;
  end

  // Read/write pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/stage_permutation_stream.sv
// ============================================================================
// Module      : stage_permutation_stream
// Description : Streaming NTT stage permutation. Output lane i takes input
//               lane j, j = i with index bits 0 and k swapped, where k is the
//               stage latched on each frame's start beat. Beats are permuted
//               on entry and then held in a two-entry valid/ready buffer.
//               Optional macro STAGE_PERM_FRAME_CHECK_EN builds a sticky
//               framing-error detector on frame_err; otherwise frame_err = 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stage_permutation_stream
  import ntt_perm_pkg::*;
#(
  parameter int DATA_WIDTH_PER_INPUT = 28,
  parameter int INPUT_PER_CYCLE      = 64,
  parameter int FRAME_BEATS          = 16
) (
  input  logic                                                   clk,
  input  logic                                                   rst,
  input  logic [$clog2(INPUT_PER_CYCLE)-1:0]                     in_stage,
  input  logic                                                   in_valid,
  output logic                                                   in_ready,
  input  logic                                                   in_start,
  input  logic [INPUT_PER_CYCLE-1:0][DATA_WIDTH_PER_INPUT-1:0]   inData,
  output logic                                                   out_valid,
  input  logic                                                   out_ready,
  output logic                                                   out_start,
  output logic [INPUT_PER_CYCLE-1:0][DATA_WIDTH_PER_INPUT-1:0]   outData,
  output logic                                                   frame_err
);

  localparam int STAGE_W     = stage_width(INPUT_PER_CYCLE);
  localparam int LANE_DATA_W = INPUT_PER_CYCLE * DATA_WIDTH_PER_INPUT;
  localparam int PAYLOAD_W   = LANE_DATA_W + 1;
  localparam int CNT_W       = $clog2(FRAME_BEATS);

  logic                                                 in_fire;
  logic [STAGE_W-1:0]                                   stage_q;
  logic [STAGE_W-1:0]                                   beat_stage;
  logic [CNT_W-1:0]                                     beat_cnt;
  logic [INPUT_PER_CYCLE-1:0][DATA_WIDTH_PER_INPUT-1:0] permuted;
  logic [PAYLOAD_W-1:0]                                 buf_out;

  assign in_fire = in_valid && in_ready;

  // A start beat already uses the stage it carries; other beats use the
  // frame's latched stage (zero, i.e. identity, until the first start).
  assign beat_stage = in_start ? in_stage : stage_q;

  // Latch the frame stage on every accepted start beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      stage_q <= '0;
    else if (in_fire && in_start) stage_q <= in_stage;
  end

  // Beat position within the current frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
    end else if (in_fire) begin
      if (in_start)                                  beat_cnt <= CNT_W'(1);
      else if (beat_cnt == CNT_W'(FRAME_BEATS - 1))  beat_cnt <= '0;
      else                                           beat_cnt <= beat_cnt + CNT_W'(1);
    end
  end

  // Lane crossbar: each output lane selects its source lane for this beat.
  // Permuting before the buffer bakes each beat's own stage into its data.
  for (genvar i = 0; i < INPUT_PER_CYCLE; i++) begin : g_lane
    logic [STAGE_W-1:0] src;
    // Source lane index for output lane i
    always_comb src = STAGE_W'(swap_lane_bits(i, int'(beat_stage), STAGE_W));
    assign permuted[i] = inData[src];
  end

  perm_skid_buffer #(
    .PAYLOAD_W (PAYLOAD_W)
  ) u_buf (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_payload  ({in_start, permuted}),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_payload (buf_out)
  );

  assign outData   = buf_out[LANE_DATA_W-1:0];
  assign out_start = out_valid && buf_out[PAYLOAD_W-1];

`ifdef STAGE_PERM_FRAME_CHECK_EN
  logic frame_seen;
  logic err_q;

  // Remember that at least one frame has started
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      frame_seen <= 1'b0;
    else if (in_fire && in_start) frame_seen <= 1'b1;
  end

  // Sticky error: start beat off a frame boundary, or a frame running long
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (in_fire) begin
      if (in_start && (beat_cnt != '0))
        err_q <= 1'b1;
      else if (!in_start && (beat_cnt == '0) && frame_seen)
        err_q <= 1'b1;
    end
  end

  assign frame_err = err_q;
`else
  logic unused_beat_cnt;
  assign unused_beat_cnt = ^beat_cnt;
  assign frame_err       = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_stage_permutation_stream.sv
// ============================================================================
// Module      : tb_stage_permutation_stream
// Description : Scoreboard bench for stage_permutation_stream. Accepted input
//               beats are turned into expected output beats by a reference
//               permutation and queued; a monitor compares every presented
//               output beat and the handshake signals against the queue.
//               Honours STAGE_PERM_FRAME_CHECK_EN for frame_err expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stage_permutation_stream;

  localparam int W     = 28;
  localparam int P     = 64;
  localparam int FB    = 16;
  localparam int SW    = 6;
  localparam int LOG2P = 6;
  localparam int DW    = P * W;

  logic          clk = 1'b0;
  logic          rst;
  logic [SW-1:0] in_stage;
  logic          in_valid;
  logic          in_ready;
  logic          in_start;
  logic [DW-1:0] inData;
  logic          out_valid;
  logic          out_ready;
  logic          out_start;
  logic [DW-1:0] outData;
  logic          frame_err;

  stage_permutation_stream #(
    .DATA_WIDTH_PER_INPUT (W),
    .INPUT_PER_CYCLE      (P),
    .FRAME_BEATS          (FB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_stage  (in_stage),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_start  (in_start),
    .inData    (inData),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_start (out_start),
    .outData   (outData),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          start;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   model_stage = 0;
  int   model_cnt   = 0;
  bit   model_started = 1'b0;
  bit   model_err   = 1'b0;
  bit   exp_err;
  bit   chk_en      = 1'b0;
  int   ready_mode  = 1;   // 0: stall, 1: always ready, 2: random

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_data(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    int bad;
    bad = -1;
    vectors++;
    for (int i = P - 1; i >= 0; i--)
      if (act[i*W +: W] !== exp[i*W +: W]) bad = i;
    if (bad >= 0) begin
      miscompares++;
      $display("FAIL %s lane %0d: got %0h expected %0h at %0t",
               name, bad, act[bad*W +: W], exp[bad*W +: W], $time);
    end
  endtask

  // Reference permutation: out lane i <- in lane (i with bits 0 and k swapped)
  function automatic logic [DW-1:0] perm_ref(input logic [DW-1:0] d, input int k);
    logic [DW-1:0] r;
    int j, b0, bk;
    for (int i = 0; i < P; i++) begin
      j = i;
      if (k > 0 && k < LOG2P) begin
        b0 = i % 2;
        bk = (i / (1 << k)) % 2;
        j  = i - b0 - bk * (1 << k) + bk + b0 * (1 << k);
      end
      r[i*W +: W] = d[j*W +: W];
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [DW-1:0] index_data();
    logic [DW-1:0] r;
    for (int j = 0; j < P; j++) r[j*W +: W] = W'(j);
    return r;
  endfunction

  task automatic model_reset();
    sb.delete();
    model_stage   = 0;
    model_cnt     = 0;
    model_started = 1'b0;
    model_err     = 1'b0;
  endtask

  task automatic model_accept(input logic start, input logic [SW-1:0] stg, input logic [DW-1:0] d);
    exp_t e;
    if (start) begin
      if (model_cnt != 0) model_err = 1'b1;
      model_stage   = int'(stg);
      model_cnt     = 1;
      model_started = 1'b1;
    end else begin
      if (model_cnt == 0 && model_started) model_err = 1'b1;
      model_cnt = (model_cnt + 1) % FB;
    end
    e.start = start;
    e.data  = perm_ref(d, model_stage);
    sb.push_back(e);
  endtask

  // Downstream ready pattern
  always @(negedge clk) begin
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor: checks handshakes and output beats, then records accepted input
  always begin
    @(negedge clk);
    #3;
    if (chk_en) begin
`ifdef STAGE_PERM_FRAME_CHECK_EN
      exp_err = model_err;
`else
      exp_err = 1'b0;
`endif
      check_val("in_ready", in_ready, (sb.size() < 2) || out_ready);
      check_val("out_valid", out_valid, sb.size() != 0);
      check_val("frame_err", frame_err, exp_err);
      if (out_valid && sb.size() != 0) begin
        check_data("outData", outData, sb[0].data);
        check_val("out_start", out_start, sb[0].start);
        if (out_ready) void'(sb.pop_front());
      end
      if (in_valid && in_ready) model_accept(in_start, in_stage, inData);
    end
  end

  task automatic send_beat(input logic start, input logic [SW-1:0] stg, input logic [DW-1:0] d);
    int waited;
    waited = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_start = start;
    in_stage = stg;
    inData   = d;
    forever begin
      #3;
      if (in_ready === 1'b1) begin
        @(posedge clk);
        break;
      end
      waited++;
      if (waited > 200) begin
        vectors++;
        miscompares++;
        $display("FAIL accept_timeout: in_ready %b expected 1 at %0t", in_ready, $time);
        @(posedge clk);
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_start = 1'b0;
    end
  endtask

  task automatic send_frame(input int k, input int nbeats, input int gap_pct);
    for (int b = 0; b < nbeats; b++) begin
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) idle(1);
      send_beat(b == 0, (b == 0) ? SW'(k) : SW'($urandom_range(0, 7)), rand_data());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_start = 1'b0;
    in_stage = '0;
    inData   = '0;
    out_ready = 1'b1;
    #2;
    check_val("rst_out_valid", out_valid, 0);
    check_data("rst_outData", outData, '0);
    check_val("rst_out_start", out_start, 0);
    check_val("rst_in_ready", in_ready, 0);
    check_val("rst_frame_err", frame_err, 0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    #1 check_val("in_ready_pre_edge", in_ready, 0);
    @(posedge clk);
    #1 check_val("in_ready_post_release", in_ready, 1);
    chk_en = 1'b1;

    // k = 5 on lane-index data, downstream always ready
    ready_mode = 1;
    send_beat(1'b1, SW'(5), index_data());
    #1;
    check_val("k5_valid", out_valid, 1);
    check_val("k5_start", out_start, 1);
    check_val("k5_lane1", outData[1*W +: W], 32);
    check_val("k5_lane32", outData[32*W +: W], 1);
    check_val("k5_lane0", outData[0 +: W], 0);
    check_val("k5_lane63", outData[63*W +: W], 63);
    for (int b = 1; b < FB; b++) send_beat(1'b0, SW'($urandom_range(0, 63)), rand_data());

    // k = 1 full frame
    send_beat(1'b1, SW'(1), index_data());
    #1;
    check_val("k1_lane1", outData[1*W +: W], 2);
    check_val("k1_lane2", outData[2*W +: W], 1);
    for (int b = 1; b < FB; b++) send_beat(1'b0, SW'($urandom_range(0, 63)), rand_data());

    // Downstream stalled while input keeps coming
    ready_mode = 0;
    fork
      send_frame(3, FB, 0);
      begin
        repeat (6) @(negedge clk);
        ready_mode = 1;
      end
    join

    // Stage changes mid-frame must wait for the next start beat
    send_beat(1'b1, SW'(5), rand_data());
    for (int b = 1; b < FB; b++) send_beat(1'b0, SW'(2), rand_data());
    send_frame(2, FB, 0);

    // Random frames, random gaps and back-pressure
    ready_mode = 2;
    repeat (12) send_frame($urandom_range(0, 7), FB, 25);

    // Start beat arriving at beat 7 of a frame
    ready_mode = 1;
    send_frame(4, 7, 0);
    send_frame(6, FB, 0);
    idle(3);

    // Reset with two beats buffered
    ready_mode = 0;
    send_beat(1'b1, SW'(3), rand_data());
    send_beat(1'b0, SW'(3), rand_data());
    idle(1);
    #1;
    chk_en = 1'b0;
    rst    = 1'b1;
    #1;
    check_val("r24_out_valid", out_valid, 0);
    check_data("r24_outData", outData, '0);
    check_val("r24_out_start", out_start, 0);
    check_val("r24_in_ready", in_ready, 0);
    check_val("r24_frame_err", frame_err, 0);
    model_reset();
    @(negedge clk);
    #1 rst = 1'b0;
    #1 check_val("r24_in_ready_pre_edge", in_ready, 0);
    @(posedge clk);
    #1 check_val("r24_in_ready_post", in_ready, 1);
    chk_en = 1'b1;

    // Beats before any start beat pass through unpermuted
    ready_mode = 1;
    send_beat(1'b0, SW'(5), index_data());
    #1;
    check_val("pre_lane1", outData[1*W +: W], 1);
    check_val("pre_lane32", outData[32*W +: W], 32);
    send_beat(1'b0, SW'(2), rand_data());
    send_frame(1, FB, 10);

    // Drain everything still expected
    ready_mode = 1;
    idle(1);
    waited = 0;
    while (sb.size() != 0 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    check_val("drain_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/stage_permutation_stream.md
STAGE_PERMUTATION_STREAM -- requirements
Module: stage_permutation_stream

Interface
REQ-001 SHALL have parameter DATA_WIDTH_PER_INPUT, default 28, bits per lane.
REQ-002 SHALL have parameter INPUT_PER_CYCLE, default 64, lane count P; power of two, 4..128.
REQ-003 SHALL have parameter FRAME_BEATS, default 16, beats per NTT frame (N/P); power of two, >=2.
REQ-004 SHALL have ports, one clock, reset asynchronous and active-high:
  clk  in  1  clock
  rst  in  1  asynchronous active-high reset
  in_stage  in  $clog2(P)  swap bit k for the frame; 0 = identity; sampled on accepted in_start beat
  in_valid  in  1  input beat valid
  in_ready  out  1  block can accept a beat
  in_start  in  1  first beat of a frame, qualified by in_valid&&in_ready
  inData  in  P x DATA_WIDTH_PER_INPUT  packed lane array, lane 0 in LSBs
  out_valid  out  1  output beat valid
  out_ready  in  1  downstream accepts
  out_start  out  1  marks first output beat of a frame
  outData  out  P x DATA_WIDTH_PER_INPUT  permuted lanes
  frame_err  out  1  sticky framing error (REQ-016 only)

Function
REQ-005 SHALL map outData lane i from inData lane j, where j is i with index bits 0 and k swapped; k=0 or k>=log2(P) gives identity.
REQ-006 SHALL transfer on in_valid&&in_ready and on out_valid&&out_ready.
REQ-007 SHALL have latency one cycle from accepted input beat to out_valid when the buffer is empty.
REQ-008 SHALL hold a 2-entry buffer; in_ready = not full; a full buffer SHALL still accept a beat when a beat leaves in the same cycle.
REQ-009 SHALL keep outData/out_start stable while out_valid && !out_ready.
REQ-010 SHALL latch in_stage into stage_q on an accepted beat with in_start=1; all beats up to the next in_start use stage_q; per-beat stage SHALL travel with the beat in the buffer.
REQ-011 SHALL run a beat counter 0..FRAME_BEATS-1: an accepted in_start beat sets it to 1; other accepted beats increment it; it wraps to 0 after FRAME_BEATS-1.
REQ-012 SHALL propagate in_start with its beat as out_start, exactly one output beat per frame.
REQ-013 SHALL permute beats accepted before the first in_start with stage 0 (identity).
REQ-014 SHALL never drop or duplicate beats under any valid/ready pattern.

Reset
REQ-015 SHALL, on rst asserted asynchronously, clear: buffer empty, out_valid=0, out_start=0, outData=0, in_ready=0 while rst high and 1 the cycle after release, stage_q=0, beat counter=0, frame_err=0; in-flight beats are discarded.

Configuration
REQ-016 With macro STAGE_PERM_FRAME_CHECK_EN defined: frame_err SHALL set the cycle after an accepted in_start arrives with beat counter !=0, or an accepted non-start beat arrives with beat counter ==0 after at least one frame has started; frame_err clears only on rst. Without it: frame_err SHALL be tied 0 and no check logic built.

Structure
REQ-017 SHALL put the lane-index swap function, the lane-array typedef and the stage-width localparam in shared package ntt_perm_pkg.
REQ-018 SHALL put the 2-entry valid/ready buffer in sub-module perm_skid_buffer, parametrised by payload width; the top permutes before the buffer.

Verification
REQ-019 P=64, k=5, lane j = j, out_ready=1 -> next cycle outData lane1=32, lane32=1, lane0=0, lane63=63.
REQ-020 P=64, k=1, one frame of 16 beats -> lane1=2, lane2=1; out_start on output beat 0 only; frame_err=0.
REQ-021 out_ready=0 for 5 cycles with continuous input -> in_ready drops after 2 beats; outData held; after release all beats arrive in order, none lost.
REQ-022 in_stage changes mid-frame from 5 to 2 -> no effect until next in_start; next frame uses k=2.
REQ-023 with STAGE_PERM_FRAME_CHECK_EN, in_start on beat 7 -> frame_err=1 next cycle, stays 1 until rst.
REQ-024 rst pulse with 2 beats buffered -> out_valid=0, outData=0 immediately; in_ready=1 one cycle after release; first post-reset beat uses identity.
